mem_port_sequencer: RTL and testbench

//  Shares one single-ported instruction/data memory between instruction fetch (IF) and

---
 rtl/mem_port_sequencer.sv | 128 ++++++++++++
 tb/tb_mem_port_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer: shares one memory port between fetch and load/store,
// with alternating-priority arbitration, req/ack handshake and timeout abort.
module mem_port_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_done_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              if_err_o,
  output logic              ls_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic [7:0] tmo_q, tmo_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic if_done_q, if_done_d, ls_done_q, ls_done_d, if_err_q, if_err_d, ls_err_q, ls_err_d;
  logic gnt_ls, tmo_hit;
  // owner/last: 1 = LS, 0 = IF; IF wins a tie only right after an LS grant
  assign gnt_ls  = ls_req_i & ~(if_req_i & last_q);
  assign tmo_hit = tmo_q == 8'(TMO_CYC - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      if_err_q    <= if_err_d;
      ls_err_q    <= ls_err_d;
    end
  end
  always_comb
    state_d = state_q == IDLE ? ((if_req_i | ls_req_i) ? BUSY : IDLE) :
              state_q == BUSY ? ((mem_ack_i | tmo_hit) ? RESP : BUSY) : IDLE;
  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    if_err_d    = 1'b0;
    ls_err_d    = 1'b0;
    if (state_q == IDLE && (if_req_i | ls_req_i)) begin
      owner_d     = gnt_ls;
      last_d      = gnt_ls;
      mem_req_d   = 1'b1;
      mem_we_d    = gnt_ls & ls_we_i;
      mem_addr_d  = gnt_ls ? ls_addr_i : if_addr_i;
      mem_wdata_d = ls_wdata_i;
    end else if (state_q == BUSY) begin
      if (mem_ack_i) begin
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        if_rdata_d = owner_q ? if_rdata_q : mem_rdata_i;
        ls_rdata_d = owner_q ? mem_rdata_i : ls_rdata_q;
        if_done_d  = ~owner_q;
        ls_done_d  = owner_q;
      end else if (tmo_hit) begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        if_err_d  = ~owner_q;
        ls_err_d  = owner_q;
      end else
        tmo_d = tmo_q + 8'd1;
    end else if (state_q == RESP)
      tmo_d = '0;
  end
  assign if_done_o   = if_done_q;
  assign ls_done_o   = ls_done_q;
  assign if_err_o    = if_err_q;
  assign ls_err_o    = ls_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stall_o     = (if_req_i & ~if_done_q) | (ls_req_i & ~ls_done_q);
endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb_mem_port_sequencer: memory responder plus per-scenario tasks checking arbitration,
// latency, timeout and reset behaviour against expectations derived from the protocol rules.
module tb_mem_port_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, mem_ack = 1'b0;
  logic [15:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
  logic if_done, ls_done, if_err, ls_err, mem_req, mem_we, stall;
  logic [15:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [15:0] mem [256];
  bit ack_en = 1'b1;
  int ack_lat = 0, rcnt = 0, unstable = 0, last_len = 0;
  typedef struct {int c; logic we; logic [15:0] a; logic [15:0] d;} gnt_t;
  gnt_t gq[$];
  logic [15:0] exp_if = '0, exp_ls = '0;
  bit lastls = 1'b0;

  mem_port_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_done_o(ls_done), .ls_rdata_o(ls_rdata), .if_err_o(if_err), .ls_err_o(ls_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .stall_o(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory: acks after ack_lat extra cycles of mem_req, returns old contents, commits writes
  initial begin
    gnt_t g;
    logic lw;
    logic [15:0] la, ld;
    lw = 1'b0; la = '0; ld = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) begin
        if (rcnt != 0) last_len = rcnt;
        rcnt = 0;
      end else begin
        rcnt++;
        if (rcnt == 1) begin
          g.c = cyc; g.we = mem_we; g.a = mem_addr; g.d = mem_wdata;
          gq.push_back(g);
        end else if ({mem_we, mem_addr, mem_wdata} !== {lw, la, ld}) unstable++;
        {lw, la, ld} = {mem_we, mem_addr, mem_wdata};
        if (ack_en && rcnt == ack_lat + 1) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr[7:0]];
          if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
        end
      end
    end
  end

  task automatic wait_resp(input int maxc, output int n, output logic idn, ldn, ier, ler);
    n = 0; {idn, ldn, ier, ler} = 4'b0;
    while (n < maxc && !(idn | ldn | ier | ler)) begin
      @(negedge clk);
      n++;
      idn = if_done; ldn = ls_done; ier = if_err; ler = ls_err;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_req = 1'b1; if_addr = 16'h0040;
    repeat (3) @(negedge clk);
    n_chk++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem: mem_req=%b mem_we=%b want 0 0", mem_req, mem_we); end
    n_chk++; if ({if_done, ls_done, if_err, ls_err} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0000", {if_done, ls_done, if_err, ls_err}); end
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", stall); end
    n_chk++; if ({if_rdata, ls_rdata, mem_addr, mem_wdata} !== 64'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", {if_rdata, ls_rdata, mem_addr, mem_wdata}); end
    if_req = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (stall !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle: stall=%b mem_req=%b want 0 0", stall, mem_req); end
  endtask

  task automatic test_lone_fetch;
    int n; logic idn, ldn, ier, ler;
    mem[8'h40] = 16'hA123; ack_lat = 2; ack_en = 1'b1; gq.delete(); unstable = 0;
    if_addr = 16'h0040; if_req = 1'b1;
    wait_resp(30, n, idn, ldn, ier, ler);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_on_done: got %b want 0", stall); end
    if_req = 1'b0;
    exp_if = 16'hA123;
    n_chk++; if ({idn, ldn, ier, ler} !== 4'b1000) begin n_fail++; $display("FAIL fetch_pulse: got %b want 1000", {idn, ldn, ier, ler}); end
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL fetch_latency: got %0d want 4", n); end
    n_chk++; if (if_rdata !== exp_if) begin n_fail++; $display("FAIL fetch_rdata: got %h want %h", if_rdata, exp_if); end
    n_chk++; if (gq.size() !== 1 || gq[0].we !== 1'b0 || gq[0].a !== 16'h0040 || unstable !== 0) begin n_fail++; $display("FAIL fetch_mem: grants=%0d unstable=%0d want 1 grant read at 0040", gq.size(), unstable); end
    @(negedge clk);
    n_chk++; if (if_done !== 1'b0) begin n_fail++; $display("FAIL fetch_one_cycle: if_done=%b want 0", if_done); end
  endtask

  task automatic test_contention;
    int n1, n2; logic idn, ldn, ier, ler; logic [15:0] old;
    ack_lat = 0; gq.delete(); unstable = 0;
    old = mem[8'h00];
    ls_we = 1'b1; ls_addr = 16'h0100; ls_wdata = 16'h1234; if_addr = 16'h0100;
    ls_req = 1'b1; if_req = 1'b1;
    wait_resp(30, n1, idn, ldn, ier, ler);
    ls_req = 1'b0;
    n_chk++; if ({idn, ldn, ier, ler} !== 4'b0100 || n1 !== 2) begin n_fail++; $display("FAIL cont_first: pulses=%b n=%0d want 0100 n=2", {idn, ldn, ier, ler}, n1); end
    exp_ls = old;
    wait_resp(30, n2, idn, ldn, ier, ler);
    if_req = 1'b0;
    exp_if = 16'h1234;
    lastls = 1'b0;
    n_chk++; if ({idn, ldn, ier, ler} !== 4'b1000 || n2 !== 3) begin n_fail++; $display("FAIL cont_second: pulses=%b n=%0d want 1000 n=3", {idn, ldn, ier, ler}, n2); end
    n_chk++; if (gq.size() !== 2) begin n_fail++; $display("FAIL cont_grants: got %0d want 2", gq.size()); end
    else begin
      n_chk++; if (gq[0].we !== 1'b1 || gq[0].a !== 16'h0100 || gq[0].d !== 16'h1234) begin n_fail++; $display("FAIL cont_store: we=%b a=%h d=%h want 1 0100 1234", gq[0].we, gq[0].a, gq[0].d); end
      n_chk++; if (gq[1].we !== 1'b0 || gq[1].a !== 16'h0100) begin n_fail++; $display("FAIL cont_fetch: we=%b a=%h want 0 0100", gq[1].we, gq[1].a); end
      n_chk++; if (gq[1].c - gq[0].c !== 3) begin n_fail++; $display("FAIL cont_spacing: got %0d want 3", gq[1].c - gq[0].c); end
    end
    n_chk++; if (if_rdata !== exp_if || ls_rdata !== exp_ls) begin n_fail++; $display("FAIL cont_rdata: if=%h ls=%h want %h %h", if_rdata, ls_rdata, exp_if, exp_ls); end
  endtask

  task automatic test_fairness;
    int n; logic idn, ldn, ier, ler; bit is_ls; logic [15:0] a, e; logic ewe;
    gq.delete(); unstable = 0; ack_lat = 0;
    ls_we = 1'($urandom); ls_addr = 16'($urandom); ls_wdata = 16'($urandom); if_addr = 16'($urandom);
    ls_req = 1'b1; if_req = 1'b1;
    for (int t = 0; t < 10; t++) begin
      is_ls = !lastls;
      a = is_ls ? ls_addr : if_addr;
      ewe = is_ls ? ls_we : 1'b0;
      e = mem[a[7:0]];
      wait_resp(40, n, idn, ldn, ier, ler);
      n_chk++; if ({idn, ldn, ier, ler} !== (is_ls ? 4'b0100 : 4'b1000)) begin n_fail++; $display("FAIL fair_owner[%0d]: pulses=%b want ls=%0d", t, {idn, ldn, ier, ler}, is_ls); end
      n_chk++; if ((is_ls ? ls_rdata : if_rdata) !== e) begin n_fail++; $display("FAIL fair_rdata[%0d]: got %h want %h", t, is_ls ? ls_rdata : if_rdata, e); end
      n_chk++; if (gq.size() !== t + 1) begin n_fail++; $display("FAIL fair_count[%0d]: got %0d want %0d", t, gq.size(), t + 1); end
      else begin
        n_chk++; if (gq[t].a !== a || gq[t].we !== ewe) begin n_fail++; $display("FAIL fair_grant[%0d]: a=%h we=%b want %h %b", t, gq[t].a, gq[t].we, a, ewe); end
      end
      if (is_ls) begin
        exp_ls = e;
        ls_we = 1'($urandom); ls_addr = 16'($urandom); ls_wdata = 16'($urandom);
      end else begin
        exp_if = e;
        if_addr = 16'($urandom);
      end
      lastls = is_ls;
      ack_lat = $urandom_range(0, 3);
    end
    ls_req = 1'b0; if_req = 1'b0;
    n_chk++; if (unstable !== 0) begin n_fail++; $display("FAIL fair_stable: got %0d changes want 0", unstable); end
  endtask

  task automatic test_timeout;
    int n; logic idn, ldn, ier, ler; logic [15:0] e;
    gq.delete(); ack_en = 1'b0;
    ls_we = 1'b0; ls_addr = 16'($urandom); ls_req = 1'b1;
    wait_resp(40, n, idn, ldn, ier, ler);
    ls_req = 1'b0;
    n_chk++; if ({idn, ldn, ier, ler} !== 4'b0001 || n !== 16) begin n_fail++; $display("FAIL tmo_err: pulses=%b n=%0d want 0001 n=16", {idn, ldn, ier, ler}, n); end
    n_chk++; if (ls_rdata !== exp_ls) begin n_fail++; $display("FAIL tmo_rdata: got %h want %h", ls_rdata, exp_ls); end
    @(negedge clk);
    n_chk++; if (last_len !== 15) begin n_fail++; $display("FAIL tmo_req_len: got %0d want 15", last_len); end
    n_chk++; if (ls_err !== 1'b0) begin n_fail++; $display("FAIL tmo_one_cycle: ls_err=%b want 0", ls_err); end
    ack_en = 1'b1; ack_lat = 14;
    ls_addr = 16'($urandom); e = mem[ls_addr[7:0]]; ls_req = 1'b1;
    wait_resp(40, n, idn, ldn, ier, ler);
    ls_req = 1'b0;
    exp_ls = e; lastls = 1'b1;
    n_chk++; if ({idn, ldn, ier, ler} !== 4'b0100 || n !== 16) begin n_fail++; $display("FAIL tmo_late_ack: pulses=%b n=%0d want 0100 n=16", {idn, ldn, ier, ler}, n); end
    n_chk++; if (ls_rdata !== exp_ls) begin n_fail++; $display("FAIL tmo_late_rdata: got %h want %h", ls_rdata, exp_ls); end
    @(negedge clk);
    n_chk++; if (last_len !== 15) begin n_fail++; $display("FAIL tmo_late_len: got %0d want 15", last_len); end
  endtask

  task automatic test_reset_mid;
    int n, bad; logic idn, ldn, ier, ler; logic [15:0] e;
    ack_en = 1'b0; if_addr = 16'($urandom); if_req = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: mem_req=%b want 1", mem_req); end
    rst_n = 1'b0; if_req = 1'b0;
    @(negedge clk);
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_drop: mem_req=%b want 0", mem_req); end
    rst_n = 1'b1; bad = 0;
    repeat (4) begin
      @(negedge clk);
      if ({if_done, ls_done, if_err, ls_err, mem_req} !== 5'b0) bad++;
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_quiet: %0d cycles with activity want 0", bad); end
    n_chk++; if (if_rdata !== 16'h0 || ls_rdata !== 16'h0) begin n_fail++; $display("FAIL rmid_rdata_clr: if=%h ls=%h want 0 0", if_rdata, ls_rdata); end
    ack_en = 1'b1; ack_lat = 1;
    if_addr = 16'($urandom); e = mem[if_addr[7:0]]; if_req = 1'b1;
    wait_resp(30, n, idn, ldn, ier, ler);
    if_req = 1'b0;
    n_chk++; if ({idn, ldn, ier, ler} !== 4'b1000 || n !== 3) begin n_fail++; $display("FAIL rmid_after: pulses=%b n=%0d want 1000 n=3", {idn, ldn, ier, ler}, n); end
    n_chk++; if (if_rdata !== e) begin n_fail++; $display("FAIL rmid_after_rdata: got %h want %h", if_rdata, e); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    @(negedge clk);
    test_reset;
    test_lone_fetch;
    test_contention;
    test_fairness;
    @(negedge clk);
    test_timeout;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
